a2d_scan_ctrl: RTL

- Sequencer for the SPI monarch. It owns the snd/cmd/done/resp handshake.
- Continuously round-robins an off-board A2D over NUM_CH slide-pot channels.
- Each conversion is two SPI transactions: the first launches the channel, the second reads the 12-bit result.
- Results land in a register file that the EQ gain logic reads combinationally.

---
 rtl/a2d_pkg.sv | 20 ++
 rtl/scan_tmr.sv | 29 ++
 rtl/a2d_scan_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// Shared types and helpers for the A2D slide-pot scan sequencer.
// Pure declarations: no logic, no latency.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    GAP,
    READ,
    NEXT
  } state_t;

  localparam logic [1:0] CMD_HDR = 2'b00;
  localparam int         RES_W   = 12;

  function automatic logic [15:0] mk_cmd(input logic [2:0] ch);
    return {CMD_HDR, ch, 11'h000};
  endfunction

endpackage

// File: rtl/scan_tmr.sv
// Auto-scan period timer: counts 0..PERIOD-1 while en=1 and is held at 0 while en=0.
// tick is combinational on the terminal count and is qualified by en; it is never stalled.
module scan_tmr #(
  parameter int unsigned PERIOD = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned   TW   = $clog2(PERIOD);
  localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (!en || (timer == LAST)) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign tick = en && (timer == LAST);

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Round-robin A2D scan sequencer: a launch and a read SPI transaction per channel, results in a register file.
// snd waits on done for every transaction; extra start requests during a scan collapse into one pending scan.
module a2d_scan_ctrl
  import a2d_pkg::*;
#(
  parameter int unsigned NUM_CH  = 7,
  parameter int unsigned PERIOD  = 20'd1_000_000,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             scan_req,
  input  logic             done,
  input  logic [15:0]      resp,
  output logic             snd,
  output logic [15:0]      cmd,
  input  logic [2:0]       rd_ch,
  output logic [RES_W-1:0] rd_data,
  output logic             busy,
  output logic             scan_done
);

  localparam int unsigned   GW      = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LD  = GW'(GAP_CYC);
  localparam logic [GW-1:0] GAP_ONE = GW'(1);
  localparam logic [2:0]    LAST_CH = 3'(NUM_CH - 1);

  state_t           state, state_nxt;
  logic [2:0]       ch, ch_nxt;
  logic [GW-1:0]    gap_cnt, gap_nxt;
  logic             pending, pending_nxt;
  logic             snd_nxt, busy_nxt, scan_done_nxt;
  logic             res_we;
  logic             tick, start, done_seen;
  logic [RES_W-1:0] res [8];
  logic             unused_resp_hi;

  scan_tmr #(
    .PERIOD (PERIOD)
  ) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  assign start = scan_req | tick | pending;

  // snd is high exactly on the first LAUNCH/READ clock, where done still shows the previous transaction.
  assign done_seen = done & ~snd;

  always_comb begin
    state_nxt     = state;
    ch_nxt        = ch;
    gap_nxt       = gap_cnt;
    pending_nxt   = pending;
    snd_nxt       = 1'b0;
    busy_nxt      = busy;
    scan_done_nxt = 1'b0;
    res_we        = 1'b0;

    if (busy && (scan_req || tick)) begin
      pending_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          snd_nxt     = 1'b1;
          busy_nxt    = 1'b1;
          pending_nxt = 1'b0;
          state_nxt   = LAUNCH;
        end
      end
      LAUNCH: begin
        if (done_seen) begin
          gap_nxt   = GAP_LD;
          state_nxt = GAP;
        end
      end
      GAP: begin
        // gap_cnt is the number of idle clocks still to run, including this one.
        if (gap_cnt <= GAP_ONE) begin
          snd_nxt   = 1'b1;
          state_nxt = READ;
        end else begin
          gap_nxt = gap_cnt - 1'b1;
        end
      end
      READ: begin
        if (done_seen) begin
          res_we = 1'b1;
          if (ch == LAST_CH) begin
            ch_nxt        = 3'd0;
            busy_nxt      = 1'b0;
            scan_done_nxt = 1'b1;
            state_nxt     = IDLE;
          end else begin
            ch_nxt    = ch + 3'd1;
            state_nxt = NEXT;
          end
        end
      end
      NEXT: begin
        snd_nxt   = 1'b1;
        state_nxt = LAUNCH;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // cmd follows ch_nxt so it settles in NEXT, one clock ahead of the launch snd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch        <= 3'd0;
      gap_cnt   <= '0;
      pending   <= 1'b0;
      snd       <= 1'b0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
      cmd       <= 16'h0000;
    end else begin
      ch        <= ch_nxt;
      gap_cnt   <= gap_nxt;
      pending   <= pending_nxt;
      snd       <= snd_nxt;
      busy      <= busy_nxt;
      scan_done <= scan_done_nxt;
      cmd       <= mk_cmd(ch_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        res[i] <= '0;
      end
    end else if (res_we) begin
      res[ch] <= resp[RES_W-1:0];
    end
  end

  assign rd_data        = (32'(rd_ch) < NUM_CH) ? res[rd_ch] : '0;
  assign unused_resp_hi = ^resp[15:RES_W];

endmodule
